// File: rtl/seq_mult.sv
// seq_mult: shift-add multiplier, one partial product per clock.
// Optional signed mode: MULT_SIGNED_EN.
//
// Ports:
//   clk, rst            clock, sync active-high reset
//   in_valid/in_ready   operand handshake (a, b, sgn)
//   out_valid/out_ready product handshake (p, 2*WIDTH bits)
//   busy                high in CALC or DONE
module seq_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    p_q;
  logic [CW-1:0]    cnt;

  logic [PW-1:0]    mcand_init;
  logic [PW-1:0]    part;
  logic [PW-1:0]    acc_nxt;
  logic             last;

`ifdef MULT_SIGNED_EN
  logic sgn_q;

  always_comb begin
    mcand_init = {{WIDTH{1'b0}}, b};
    if (sgn)
      mcand_init = {{WIDTH{b[WIDTH-1]}}, b};
  end
`else
  logic unused_sgn;

  assign unused_sgn = sgn;

  always_comb begin
    mcand_init = {{WIDTH{1'b0}}, b};
  end
`endif

  assign last = (cnt == LAST);

  // Final CALC edge weighs the multiplier MSB.
  // In signed mode that bit is negative, so
  // its partial product is subtracted.
  always_comb begin
    part    = a_sr[0] ? mcand : '0;
    acc_nxt = acc + part;
`ifdef MULT_SIGNED_EN
    if (sgn_q && last)
      acc_nxt = acc - part;
`endif
  end

  assign in_ready  = (state == IDLE);
  assign busy      = !in_ready;
  assign out_valid = (state == DONE);
  assign p         = p_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      mcand <= '0;
      acc   <= '0;
      p_q   <= '0;
      cnt   <= '0;
`ifdef MULT_SIGNED_EN
      sgn_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            mcand <= mcand_init;
            acc   <= '0;
            cnt   <= '0;
`ifdef MULT_SIGNED_EN
            sgn_q <= sgn;
`endif
            state <= CALC;
          end
        end
        CALC: begin
          acc   <= acc_nxt;
          a_sr  <= a_sr >> 1;
          mcand <= mcand << 1;
          cnt   <= cnt + CW'(1);
          if (last) begin
            // p only moves when a product
            // completes, so it never shows
            // a partial sum.
            p_q   <= acc_nxt;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: scoreboard bench for seq_mult.
// Instances at WIDTH=4 and WIDTH=8.
module tb_seq_mult;

  logic clk;
  logic rst;

  logic       in_valid4, in_ready4, sgn4;
  logic       out_valid4, out_ready4, busy4;
  logic [3:0] a4, b4;
  logic [7:0] p4;

  logic        in_valid8, in_ready8, sgn8;
  logic        out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int checks = 0;
  int errors = 0;
  int n8_out = 0;

  logic [63:0] q4[$];
  logic [63:0] q8[$];

  seq_mult #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .sgn(sgn4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .p(p4), .busy(busy4)
  );

  seq_mult #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sgn(sgn8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .p(p8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer multiply of the
  // operands as numbers, reduced mod 2^(2w).
  function automatic logic [63:0] ref_mul(
    input int w, input logic [31:0] x,
    input logic [31:0] y, input logic s);
    longint xv, yv, pr;
    logic [63:0] mask;
    logic sig;
    xv  = longint'(x);
    yv  = longint'(y);
    sig = 1'b0;
`ifdef MULT_SIGNED_EN
    sig = s;
`else
    if (s) sig = 1'b0;
`endif
    if (sig && x[w-1]) xv = xv - (longint'(1) << w);
    if (sig && y[w-1]) yv = yv - (longint'(1) << w);
    pr   = xv * yv;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(pr) & mask;
  endfunction

  task automatic chk(input string name,
    input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h",
               name, act, exp);
    end
  endtask

  // Monitors: pop on every product handshake.
  always @(negedge clk) begin
    if (!rst && out_valid4 && out_ready4) begin
      if (q4.size() == 0) begin
        chk("sb4_unexpected", 64'(p4), 64'hx);
      end else begin
        chk("sb4_product", 64'(p4), q4.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid8 && out_ready8) begin
      n8_out++;
      if (q8.size() == 0) begin
        chk("sb8_unexpected", 64'(p8), 64'hx);
      end else begin
        chk("sb8_product", 64'(p8), q8.pop_front());
      end
    end
  end

  // One W=4 transaction with out_ready high,
  // checking latency and return to IDLE.
  task automatic do4(input logic [3:0] x,
    input logic [3:0] y, input logic s);
    @(posedge clk); #1;
    in_valid4  = 1'b1;
    a4         = x;
    b4         = y;
    sgn4       = s;
    out_ready4 = 1'b1;
    chk("do4_idle", 64'(in_ready4), 64'd1);
    q4.push_back(ref_mul(4, 32'(x), 32'(y), s));
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    a4 = 4'($urandom);
    b4 = 4'($urandom);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk("do4_latency", 64'(out_valid4),
          64'(k == 4));
    end
    @(posedge clk); #1;
    chk("do4_back_idle", 64'(in_ready4), 64'd1);
  endtask

  initial begin
    int accepts;
    int cyc;
    int last_cyc;
    bit took;

    rst = 1'b1;
    in_valid4 = 0; out_ready4 = 0;
    a4 = 0; b4 = 0; sgn4 = 0;
    in_valid8 = 0; out_ready8 = 0;
    a8 = 0; b8 = 0; sgn8 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready", 64'(in_ready4), 64'd1);
    chk("rst_busy", 64'(busy4), 64'd0);
    chk("rst_out_valid", 64'(out_valid4), 64'd0);
    chk("rst_p", 64'(p4), 64'd0);
    chk("rst_p8", 64'(p8), 64'd0);

    // 15 x 15, max unsigned product.
    do4(4'd15, 4'd15, 1'b0);

    // 9 x 6 with output stalled.
    @(posedge clk); #1;
    in_valid4 = 1'b1; a4 = 4'd9; b4 = 4'd6;
    sgn4 = 1'b0; out_ready4 = 1'b0;
    q4.push_back(ref_mul(4, 32'd9, 32'd6, 1'b0));
    @(posedge clk); #1;
    in_valid4 = 1'b1;
    a4 = 4'd3; b4 = 4'd3;
    repeat (4) @(posedge clk);
    #1 chk("stall_valid", 64'(out_valid4), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("stall_p", 64'(p4), 64'h36);
      chk("stall_in_ready", 64'(in_ready4), 64'd0);
    end
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    chk("stall_taken", 64'(in_ready4), 64'd1);
    chk("stall_busy", 64'(busy4), 64'd0);

    // 7 x 7 aborted by reset mid-CALC.
    @(posedge clk); #1;
    in_valid4 = 1'b1; a4 = 4'd7; b4 = 4'd7;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", 64'(out_valid4), 64'd0);
    chk("abort_p", 64'(p4), 64'd0);
    chk("abort_in_ready", 64'(in_ready4), 64'd1);
    do4(4'd3, 4'd5, 1'b0);
    chk("abort_p_after", 64'(p4), 64'h0F);

    // Signed select; reference follows the build.
    do4(4'h8, 4'h8, 1'b1);
    do4(4'h8, 4'h7, 1'b1);
    do4(4'hF, 4'h1, 1'b1);
    do4(4'h8, 4'h8, 1'b0);
    do4(4'hF, 4'h1, 1'b0);
    for (int i = 0; i < 12; i++)
      do4(4'($urandom), 4'($urandom),
          1'($urandom));

    // W=8: 255 x 255, latency 8.
    @(posedge clk); #1;
    in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    out_ready8 = 1'b1;
    q8.push_back(ref_mul(8, 32'hFF, 32'hFF, 1'b0));
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk("w8_latency", 64'(out_valid8),
          64'(k == 8));
    end
    @(posedge clk); #1;

    // W=8: back-to-back, in_valid held high.
    in_valid8 = 1'b1;
    a8 = 8'($urandom); b8 = 8'($urandom);
    accepts = 0; cyc = 0; last_cyc = -1;
    while (accepts < 100 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      took = in_ready8;
      if (took) begin
        q8.push_back(ref_mul(8, 32'(a8),
                     32'(b8), 1'b0));
        if (last_cyc >= 0)
          chk("b2b_period",
              64'(cyc - last_cyc), 64'd10);
        last_cyc = cyc;
        accepts++;
      end
      @(posedge clk); #1;
      if (took) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
      end
    end
    in_valid8 = 1'b0;
    chk("b2b_accepts", 64'(accepts), 64'd100);
    for (int k = 0; k < 50 && q8.size() != 0; k++)
      @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_drain8", 64'(q8.size()), 64'd0);
    chk("b2b_count8", 64'(n8_out), 64'd101);
    chk("drain4", 64'(q4.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult.md
# seq_mult

Parametrised sequential shift-add multiplier: the next-generation multiplier for the arithmetic datapath. It replaces the single-cycle 4×4 array multiplier where area matters more than latency. It accepts one operand pair over a valid/ready handshake and retires one partial product per clock. The full 2·WIDTH-bit product is returned over a second valid/ready handshake. Optional two's-complement operation is compiled in by macro.

## Interface
- WIDTH, default 4: operand width in bits; legal range 2..32. Product width is 2·WIDTH.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  operand pair on a/b (and sgn) is valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  multiplier operand.
- b  input  WIDTH  multiplicand operand.
- sgn  input  1  per-transaction signed select; sampled with a/b; ignored unless MULT_SIGNED_EN is defined.
- out_valid  output  1  p holds a completed product.
- out_ready  input  1  consumer accepts p.
- p  output  2·WIDTH  product.
- busy  output  1  high while in CALC or DONE.

## Operation
- FSM states: IDLE, CALC, DONE. State is IDLE at reset.
- Combinational outputs:
  - in_ready = (state==IDLE).
  - busy = !in_ready.
  - out_valid = (state==DONE).
- IDLE:
  - On in_valid && in_ready && !rst, capture a into a shift register and b (zero- or sign-extended) into a 2·WIDTH multiplicand register.
  - Clear the accumulator and set bit counter cnt=0. Latch sgn. Go to CALC.
- CALC, one edge per bit:
  - If a_sr[0], acc += mcand. Then a_sr >>= 1, mcand <<= 1, cnt++.
  - After the edge with cnt==WIDTH-1, go to DONE.
- Arithmetic:
  - acc is 2·WIDTH bits; all sums are modulo 2^(2·WIDTH).
  - The unsigned product never overflows; max is (2^W−1)², e.g. 0xE1 for W=4.
- DONE:
  - p = acc, held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE. Next accept is possible on the following edge.
- Throughput: one transaction per WIDTH+2 cycles with out_ready held high. There is no overlap of input and output transactions.
- in_valid while busy is ignored. The operand is not consumed, and a/b may change freely.
- p is undefined-free: it holds the last acc value in all states. It is 0 after reset until the first completed product.

## Timing
- Accept edge E0 → CALC for edges E1..EW → out_valid is high in the cycle after EW.
  - Latency from accept edge to out_valid is WIDTH edges; for W=4, out_valid rises 4 edges after acceptance.
- out_valid stays high until an edge with out_ready=1; that edge returns the FSM to IDLE, and in_ready is high in the next cycle.
- Reset values: state=IDLE, acc=0, p=0, out_valid=0, busy=0, in_ready=1, cnt=0.
- A handshake present on an edge where rst=1 is discarded.
- Reset mid-operation (CALC or DONE): the transaction is dropped with no output, and all state is restored to reset values on that edge.
- a=0 or b=0 still takes the full WIDTH cycles. There is no early termination.

## Configuration
- MULT_SIGNED_EN defined:
  - When the latched sgn=1, a and b are two's complement and b is sign-extended into mcand.
  - On the final CALC edge (cnt==WIDTH-1, the MSB of a), acc −= mcand if the bit is set, instead of acc += mcand.
  - p is the two's-complement 2·WIDTH product.
  - When sgn=0, behaviour is identical to the unsigned path.
- MULT_SIGNED_EN undefined:
  - sgn is unconnected internally; all transactions are unsigned; no subtract path is synthesised.
  - Port list is unchanged.

## Test plan
- W=4, unsigned, a=15, b=15, out_ready=1 → out_valid rises 4 edges after accept, p=0x00E1; in_ready returns high 1 cycle after the product is taken.
- W=4, a=9, b=6, out_ready=0 for 5 cycles after out_valid → p=0x0036 held stable, in_ready=0 throughout; taken on out_ready=1, then IDLE.
- W=4, accept a=7, b=7, assert rst on the 2nd CALC edge → next cycle out_valid=0, p=0, in_ready=1; a following 3×5 yields p=0x000F with no residue.
- W=4 with MULT_SIGNED_EN, sgn=1:
  - −8×−8 → p=0x40.
  - −8×7 → p=0xC8.
  - −1×1 → p=0xFF.
  - sgn=0, 0x8×0x8 → p=0x40 and 0xF×0x1 → p=0x0F.
- W=8, 255×255 → p=0xFE01 after 8 edges.
- W=8, back-to-back accept: in_valid held high with 100 random pairs → every product matches the reference multiply, one accept per 10 cycles, no dropped or duplicated outputs.
